// File: rtl/mcse_ahb_pkg.sv
// rtl/mcse_ahb_pkg.sv - AHB-Lite encodings and requester state type shared by the MCSE
package mcse_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DRAIN,
    S_ERR,
    S_DONE
  } ahb_req_state_e;

  function automatic logic [2:0] hburst_for_beats(input int nb);
    case (nb)
      4:       return HBURST_INCR4;
      8:       return HBURST_INCR8;
      16:      return HBURST_INCR16;
      default: return HBURST_INCR;
    endcase
  endfunction

endpackage

// File: rtl/mcse_ahb_requester.sv
// rtl/mcse_ahb_requester.sv - turns one MCSE bus request into a pipelined AHB-Lite INCR burst
module mcse_ahb_requester
  import mcse_ahb_pkg::*;
#(
  parameter int pAHB_ADDR_WIDTH    = 32,
  parameter int pAHB_DATA_WIDTH    = 32,
  parameter int pPAYLOAD_SIZE_BITS = 256,
  parameter int pAHB_HRESP_WIDTH   = 2,
  parameter int pAHB_BURST_WIDTH   = 3,
  parameter int pAHB_PROT_WIDTH    = 4,
  parameter int pAHB_SIZE_WIDTH    = 3,
  parameter int pAHB_TRANS_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bus_go,
  input  logic [pAHB_ADDR_WIDTH-1:0]    bus_addr,
  input  logic [pPAYLOAD_SIZE_BITS-1:0] bus_write,
  input  logic                          bus_RW,
  output logic                          bus_done,
  output logic                          bus_err,
  output logic [pPAYLOAD_SIZE_BITS-1:0] bus_rdData,
  input  logic [pAHB_DATA_WIDTH-1:0]    I_hrdata,
  input  logic                          I_hready,
  input  logic [pAHB_HRESP_WIDTH-1:0]   I_hresp,
  output logic [pAHB_ADDR_WIDTH-1:0]    O_haddr,
  output logic [pAHB_BURST_WIDTH-1:0]   O_hburst,
  output logic                          O_hmastlock,
  output logic [pAHB_PROT_WIDTH-1:0]    O_hprot,
  output logic                          O_hnonsec,
  output logic [pAHB_SIZE_WIDTH-1:0]    O_hsize,
  output logic [pAHB_TRANS_WIDTH-1:0]   O_htrans,
  output logic [pAHB_DATA_WIDTH-1:0]    O_hwdata,
  output logic                          O_hwrite
);

  localparam int NB       = pPAYLOAD_SIZE_BITS / pAHB_DATA_WIDTH;
  localparam int BLK_BITS = $clog2(NB * 4);
  localparam int CW       = $clog2(NB + 1);
  localparam int PW       = $clog2(pPAYLOAD_SIZE_BITS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

  ahb_req_state_e                        r_state;
  logic [pAHB_ADDR_WIDTH-1:BLK_BITS]     r_base_hi;
  logic [pPAYLOAD_SIZE_BITS-1:0]         r_payload;
  logic [pPAYLOAD_SIZE_BITS-1:0]         r_rd;
  logic                                  r_rw;
  logic                                  r_dact;
  logic [CW-1:0]                         r_acnt;
  logic [CW-1:0]                         r_dcnt;

  logic [CW-1:0]                         w_anext;
  logic [BLK_BITS-1:0]                   w_off;
  logic [PW-1:0]                         w_aidx;
  logic [PW-1:0]                         w_didx;
  logic                                  w_misaligned;
  logic                                  w_err_hit;
  logic [pPAYLOAD_SIZE_BITS-1:0]         w_rd_next;

  assign O_hburst    = hburst_for_beats(NB);
  assign O_hsize     = HSIZE_WORD;
  assign O_hprot     = HPROT_DEFAULT;
  assign O_hmastlock = 1'b0;
  assign O_hnonsec   = 1'b0;

  // Offset arithmetic is confined to the aligned block so a burst never leaves it.
  assign w_anext      = r_acnt + 1'b1;
  assign w_off        = BLK_BITS'({w_anext, 2'b00});
  assign w_aidx       = PW'({r_acnt, 5'b00000});
  assign w_didx       = PW'({r_dcnt, 5'b00000});
  assign w_misaligned = |bus_addr[BLK_BITS-1:0];
  assign w_err_hit    = r_dact && !I_hready && (I_hresp != HRESP_OKAY);

  always_comb begin
    w_rd_next = r_rd;
    if (r_dact && I_hready && !r_rw) begin
      w_rd_next[w_didx +: 32] = I_hrdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_base_hi  <= '0;
      r_payload  <= '0;
      r_rd       <= '0;
      r_rw       <= 1'b0;
      r_dact     <= 1'b0;
      r_acnt     <= '0;
      r_dcnt     <= '0;
      bus_done   <= 1'b0;
      bus_err    <= 1'b0;
      bus_rdData <= '0;
      O_haddr    <= '0;
      O_htrans   <= HTRANS_IDLE;
      O_hwdata   <= '0;
      O_hwrite   <= 1'b0;
    end else begin
      bus_done <= 1'b0;
      r_rd     <= w_rd_next;
      case (r_state)
        S_IDLE: begin
          if (bus_go) begin
            r_base_hi <= bus_addr[pAHB_ADDR_WIDTH-1:BLK_BITS];
            r_payload <= bus_write;
            r_rw      <= bus_RW;
            r_rd      <= '0;
            r_acnt    <= '0;
            r_dcnt    <= '0;
            r_dact    <= 1'b0;
            bus_err   <= w_misaligned;
            if (w_misaligned) begin
              r_state    <= S_DONE;
              bus_done   <= 1'b1;
              bus_rdData <= '0;
            end else begin
              r_state  <= S_ADDR;
              O_htrans <= HTRANS_NONSEQ;
              O_haddr  <= bus_addr;
              O_hwrite <= bus_RW;
            end
          end
        end

        S_ADDR: begin
          if (w_err_hit) begin
            r_state  <= S_ERR;
            r_dact   <= 1'b0;
            O_htrans <= HTRANS_IDLE;
            O_hwrite <= 1'b0;
          end else if (I_hready) begin
            if (r_dact) begin
              r_dcnt <= r_dcnt + 1'b1;
            end
            r_dact <= 1'b1;
            r_acnt <= w_anext;
            if (r_rw) begin
              O_hwdata <= r_payload[w_aidx +: 32];
            end
            if (r_acnt == LAST_BEAT) begin
              r_state  <= S_DRAIN;
              O_htrans <= HTRANS_IDLE;
              O_hwrite <= 1'b0;
            end else begin
              O_htrans <= HTRANS_SEQ;
              O_haddr  <= {r_base_hi, w_off};
            end
          end
        end

        // Only the last beat's data phase remains in flight here.
        S_DRAIN: begin
          if (w_err_hit) begin
            r_state <= S_ERR;
            r_dact  <= 1'b0;
          end else if (I_hready) begin
            r_state    <= S_DONE;
            r_dact     <= 1'b0;
            bus_done   <= 1'b1;
            bus_rdData <= w_rd_next;
          end
        end

        S_ERR: begin
          if (I_hready) begin
            r_state    <= S_DONE;
            bus_done   <= 1'b1;
            bus_err    <= 1'b1;
            bus_rdData <= r_rd;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
